shifter_right_seq: RTL

SHIFTER_RIGHT_SEQ -- requirements
Module: shifter_right_seq

---
 rtl/shifter_right_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shifter_right_seq.sv
// ---------------------------------------------------------------------------
// shifter_right_seq
// Multi-cycle barrel shifter that shifts right one binary stage per clock.
// A start accepted in IDLE or DONE captures the operand, the shift amount
// and the fill mode. The block then spends one cycle per stage, for STAGES
// cycles in total, and finally presents the result with a one-cycle done
// pulse. Every shift takes the same time, so the latency never depends on
// the shift amount.
//
// Ports
//   clk     : rising-edge clock for all state
//   rst_n   : asynchronous active-low reset
//   start   : request a new shift (ignored while a shift is in flight)
//   a       : operand to shift right
//   b       : shift amount; only b[STAGES-1:0] is used
//   arith   : 1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy    : high while the stages are being processed
//   done    : one-cycle pulse in the cycle the result becomes valid
//   result  : shifted value, held until the next operation completes
// ---------------------------------------------------------------------------
module shifter_right_seq #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                w_accept;
    logic                w_lastStage;
    logic [WIDTH-1:0]    r_work;
    logic [STAGES-1:0]   r_shamt;
    logic                r_arith;
    logic                r_opMsb;
    logic [CW-1:0]       r_stage;
    logic                w_fill;
    logic [WIDTH-1:0]    w_shifted;
    logic                w_unusedBits;

    // The upper shift-amount bits have no meaning for this width. They are
    // folded into a deliberately unused net so the intent stays visible.
    assign w_unusedBits = ^b[WIDTH-1:STAGES];

    // The fill bit is the MSB of the operand as it was captured. It is
    // never taken from the live input, which may change mid-flight.
    assign w_fill      = r_arith & r_opMsb;
    assign w_lastStage = (r_stage == CW'(STAGES - 1));

    // State register. Reset forces IDLE at once, without waiting for a
    // clock edge, so busy and done drop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. A start is only honoured outside SHIFT.
    // DONE accepts a start directly, which gives back-to-back operations
    // with no idle gap between them. busy and done are decoded from
    // mutually exclusive states, so they can never be high together.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_lastStage) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = S_SHIFT;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // One stage of the shift network, selected by the stage counter. Stage
    // k moves the word by 2^k when bit k of the captured amount is set. The
    // vacated high bits are then OR-ed with the fill pattern.
    always_comb begin
        w_shifted = r_work;
        for (int k = 0; k < STAGES; k++) begin
            if ((r_stage == CW'(k)) && r_shamt[k]) begin
                w_shifted = (r_work >> (2 ** k))
                          | ({WIDTH{w_fill}} & ~(ONES >> (2 ** k)));
            end
        end
    end

    // Datapath registers. On acceptance the operands are captured and the
    // stage counter restarts. In SHIFT the working word advances one stage
    // per cycle. On the last stage the same edge also copies the final
    // value into result, so result only changes once per operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_shamt <= '0;
            r_arith <= 1'b0;
            r_opMsb <= 1'b0;
            r_stage <= '0;
            result  <= '0;
        end else if (w_accept) begin
            r_work  <= a;
            r_shamt <= b[STAGES-1:0];
            r_arith <= arith;
            r_opMsb <= a[WIDTH-1];
            r_stage <= '0;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_shifted;
            if (w_lastStage) begin
                r_stage <= '0;
                result  <= w_shifted;
            end else begin
                r_stage <= r_stage + CW'(1);
            end
        end
    end

endmodule
